move_step_player: RTL and testbench
===================================

// Module: move_step_player
// PURPOSE
//  Parametrised successor to the single-button step display on the 8-puzzle top.
//  Buffers the solver's move sequence through a valid/ready stream, debounces the
//  board button, and advances one move per press. Drives DIGITS 7-segment digits
//  showing the current move, the step number and the player status.
//  Sits between the solver core and the board segment pins.
// PARAMETERS
//  MAX_MOVES        32  move buffer depth, 1..99
//  DEBOUNCE_CYCLES  4   consecutive stable synced samples needed to accept a btn level
//                       (boards override, e.g. 500000)
//  DIGITS           4   number of 7-seg digits driven, >=4
// PORTS
//  clk       in   1          system clock, rising edge
//  rst       in   1          asynchronous reset, active-high
//  start     in   1          1-cycle pulse: clear buffer, enter LOAD
//  btn       in   1          raw push button, async, active-high
//  mv_valid  in   1          move beat valid
//  mv_data   in   2          0=up 1=down 2=left 3=right
//  mv_last   in   1          final move of sequence, qualified by mv_valid
//  mv_ready  out  1          player accepts a move this cycle
//  step      out  7          moves shown so far, 0..count
//  done      out  1          all buffered moves shown
//  ovf       out  1          buffer filled before mv_last
//  seg       out  7*DIGITS   digit i = seg[7i+6:7i], active-low, gfedcba
// BEHAVIOUR
//  Reset (async, rst=1): state=LOAD, count=0, step=0, done=0, ovf=0, mv_ready=0,
//   sync/debounce regs=0, accepted btn level=0, seg all 7'b1111111.
//   mv_ready first rises the cycle after rst deasserts.
//  Button: 2-FF synchroniser -> counter of consecutive cycles sync!=accepted.
//   When it reaches DEBOUNCE_CYCLES, accepted flips and the counter clears.
//   Any sample equal to accepted clears the counter.
//   press = 1-cycle pulse on an accepted 0->1 flip; a release generates none.
//  FSM states:
//   LOAD:
//    mv_ready=(count<MAX_MOVES); beat accepted when mv_valid&mv_ready, stored at buf[count].
//    Accepted with mv_last -> WAIT.
//    Accepted without mv_last making count==MAX_MOVES -> ovf=1, WAIT.
//    press ignored.
//   WAIT:
//    mv_ready=0; press -> step+1.
//    If the new step==count -> DONE, done=1.
//    count==0 cannot occur (LOAD exits only on an accepted beat).
//   DONE: press -> step=0, done=0, WAIT (replay). Buffer and ovf kept.
//   Any state: start=1 -> count=0, step=0, done=0, ovf=0, LOAD.
//    start beats a same-cycle press or mv beat (beat is dropped; mv_ready is 0 that cycle).
//  Display (registered, updates the cycle after step/state changes):
//   digit0: move buf[step-1]; codes U=1000001 d=0100001 L=1000111 r=0101111.
//           Blank 1111111 when step==0.
//   digit1/digit2: step ones/tens BCD, kept as counters alongside step.
//           Active-low 0..9 = 1000000,1111001,0100100,0110000,0011001,
//           0010010,0000010,1111000,0000000,0010000.
//   digit3: '-'=0111111 in LOAD, blank in WAIT, 'E'=0000110 in DONE.
//           'F'=0001110 overrides whenever ovf=1.
//   digits 4..DIGITS-1 blank.
//  step, done, ovf, mv_ready are registered state outputs.
//  Press-to-display latency: press pulse at cycle t -> step at t+1, seg at t+2.
// TESTING
//  T1 reset:
//   rst=1 mid-LOAD with 3 moves buffered -> all outputs at reset values.
//   After release: count=0, mv_ready=1 next cycle.
//  T2 load+play:
//   stream 1,2,3(last), then 3 clean presses.
//   step 1,2,3; digit0 d,L,r; digit1 1,2,3; done=1 and digit3=E after press 3.
//  T3 bounce:
//   btn toggles every 2 cycles for 20 cycles, then held 1 for 10 cycles (DEBOUNCE_CYCLES=4).
//   Exactly one step increment.
//  T4 overflow (MAX_MOVES=4):
//   stream 5 beats, no mv_last.
//   Beats 1-4 accepted, mv_ready=0 on the 5th; ovf=1, digit3=F, state WAIT.
//  T5 replay/edge:
//   press in DONE -> step=0, digit0 blank, done=0.
//   start and press in the same cycle -> LOAD, step=0, ovf=0.
//  T6 tens carry (MAX_MOVES=12):
//   load 12 moves, press 10x -> digit2=1111001, digit1=1000000.

Source files
------------

// File: rtl/move_step_player.sv
// Buffers a solver move stream and steps through it one move per debounced button press.
// Drives 7-seg digits with the current move, BCD step number and player status.
module move_step_player #(
   parameter int MAX_MOVES       = 32,
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int DIGITS          = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  btn,
   input  logic                  mv_valid,
   input  logic [1:0]            mv_data,
   input  logic                  mv_last,
   output logic                  mv_ready,
   output logic [6:0]            step,
   output logic                  done,
   output logic                  ovf,
   output logic [7*DIGITS-1:0]   seg
);

   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int IW  = (MAX_MOVES > 1) ? $clog2(MAX_MOVES) : 1;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;

   typedef enum logic [1:0] {S_LOAD, S_WAIT, S_DONE} state_t;

   function automatic logic [6:0] move_code(input logic [1:0] m);
      case (m)
         2'd0:    move_code = 7'b1000001;
         2'd1:    move_code = 7'b0100001;
         2'd2:    move_code = 7'b1000111;
         default: move_code = 7'b0101111;
      endcase
   endfunction

   function automatic logic [6:0] bcd_code(input logic [3:0] d);
      case (d)
         4'd0:    bcd_code = 7'b1000000;
         4'd1:    bcd_code = 7'b1111001;
         4'd2:    bcd_code = 7'b0100100;
         4'd3:    bcd_code = 7'b0110000;
         4'd4:    bcd_code = 7'b0011001;
         4'd5:    bcd_code = 7'b0010010;
         4'd6:    bcd_code = 7'b0000010;
         4'd7:    bcd_code = 7'b1111000;
         4'd8:    bcd_code = 7'b0000000;
         4'd9:    bcd_code = 7'b0010000;
         default: bcd_code = SEG_BLANK;
      endcase
   endfunction

   // ---------------- button synchroniser and debounce ----------------
   logic           sync1_q, sync2_q;
   logic           acc_q, acc_d;
   logic           press_q, press_d;
   logic [DBW-1:0] db_cnt_q, db_cnt_d;

   always_comb begin
      acc_d    = acc_q;
      press_d  = 1'b0;
      db_cnt_d = '0;
      if (sync2_q != acc_q) begin
         if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
            acc_d   = ~acc_q;
            press_d = ~acc_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         acc_q    <= 1'b0;
         press_q  <= 1'b0;
         db_cnt_q <= '0;
      end else begin
         sync1_q  <= btn;
         sync2_q  <= sync1_q;
         acc_q    <= acc_d;
         press_q  <= press_d;
         db_cnt_q <= db_cnt_d;
      end
   end

   // ---------------- player FSM ----------------
   state_t     state_q;
   logic [6:0] count_q, step_q;
   logic [3:0] ones_q, tens_q;
   logic       done_q, ovf_q, rdy_q;
   logic [1:0] buf_q [MAX_MOVES];
   logic       beat_acc;

   // start drops a same-cycle beat, so ready is masked combinationally by it
   assign beat_acc = (state_q == S_LOAD) && mv_valid && rdy_q && !start;

   always_ff @(posedge clk) begin
      if (beat_acc) buf_q[count_q[IW-1:0]] <= mv_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_LOAD;
         count_q <= '0;
         step_q  <= '0;
         ones_q  <= '0;
         tens_q  <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         rdy_q   <= 1'b0;
      end else if (start) begin
         state_q <= S_LOAD;
         count_q <= '0;
         step_q  <= '0;
         ones_q  <= '0;
         tens_q  <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         case (state_q)
            S_LOAD: begin
               rdy_q <= (count_q < 7'(MAX_MOVES));
               if (beat_acc) begin
                  count_q <= count_q + 7'd1;
                  if (mv_last) begin
                     state_q <= S_WAIT;
                     rdy_q   <= 1'b0;
                  end else if (count_q == 7'(MAX_MOVES - 1)) begin
                     state_q <= S_WAIT;
                     ovf_q   <= 1'b1;
                     rdy_q   <= 1'b0;
                  end
               end
            end
            S_WAIT: begin
               rdy_q <= 1'b0;
               if (press_q) begin
                  step_q <= step_q + 7'd1;
                  if (ones_q == 4'd9) begin
                     ones_q <= 4'd0;
                     tens_q <= tens_q + 4'd1;
                  end else begin
                     ones_q <= ones_q + 4'd1;
                  end
                  if (step_q + 7'd1 == count_q) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               rdy_q <= 1'b0;
               if (press_q) begin
                  state_q <= S_WAIT;
                  step_q  <= '0;
                  ones_q  <= '0;
                  tens_q  <= '0;
                  done_q  <= 1'b0;
               end
            end
            default: state_q <= S_LOAD;
         endcase
      end
   end

   // ---------------- display ----------------
   logic [7*DIGITS-1:0] seg_q, seg_d;
   logic [6:0]          rd_idx;

   assign rd_idx = step_q - 7'd1;

   always_comb begin
      seg_d = {DIGITS{SEG_BLANK}};
      if (step_q != 7'd0) seg_d[6:0] = move_code(buf_q[rd_idx[IW-1:0]]);
      seg_d[13:7]  = bcd_code(ones_q);
      seg_d[20:14] = bcd_code(tens_q);
      if (ovf_q) begin
         seg_d[27:21] = SEG_F;
      end else begin
         case (state_q)
            S_LOAD:  seg_d[27:21] = SEG_DASH;
            S_DONE:  seg_d[27:21] = SEG_E;
            default: seg_d[27:21] = SEG_BLANK;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) seg_q <= {DIGITS{SEG_BLANK}};
      else     seg_q <= seg_d;
   end

   assign mv_ready = rdy_q && !start;
   assign step     = step_q;
   assign done     = done_q;
   assign ovf      = ovf_q;
   assign seg      = seg_q;

endmodule

// File: tb/tb_move_step_player.sv
// Scoreboard bench for move_step_player: expected display states are queued by the
// stimulus and popped by a monitor whenever step/done/ovf change.
module tb_move_step_player;

   localparam int MAXM = 12;
   localparam int DEB  = 4;
   localparam int DIG  = 5;

   localparam logic [6:0] BL   = 7'b1111111;
   localparam logic [6:0] UP   = 7'b1000001;
   localparam logic [6:0] DN   = 7'b0100001;
   localparam logic [6:0] LF   = 7'b1000111;
   localparam logic [6:0] RT   = 7'b0101111;
   localparam logic [6:0] DASH = 7'b0111111;
   localparam logic [6:0] EE   = 7'b0000110;
   localparam logic [6:0] FF   = 7'b0001110;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start = 1'b0;
   logic              btn = 1'b0;
   logic              mv_valid = 1'b0;
   logic [1:0]        mv_data = 2'd0;
   logic              mv_last = 1'b0;
   logic              mv_ready;
   logic [6:0]        step;
   logic              done;
   logic              ovf;
   logic [7*DIG-1:0]  seg;

   move_step_player #(.MAX_MOVES(MAXM), .DEBOUNCE_CYCLES(DEB), .DIGITS(DIG)) dut (
      .clk(clk), .rst(rst), .start(start), .btn(btn),
      .mv_valid(mv_valid), .mv_data(mv_data), .mv_last(mv_last), .mv_ready(mv_ready),
      .step(step), .done(done), .ovf(ovf), .seg(seg)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] step;
      logic       done;
      logic       ovf;
      logic [6:0] d0, d1, d2, d3;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   function automatic logic [6:0] mcode(input int m);
      case (m)
         0:       mcode = UP;
         1:       mcode = DN;
         2:       mcode = LF;
         default: mcode = RT;
      endcase
   endfunction

   function automatic logic [6:0] dcode(input int d);
      case (d)
         0: dcode = 7'b1000000;  1: dcode = 7'b1111001;
         2: dcode = 7'b0100100;  3: dcode = 7'b0110000;
         4: dcode = 7'b0011001;  5: dcode = 7'b0010010;
         6: dcode = 7'b0000010;  7: dcode = 7'b1111000;
         8: dcode = 7'b0000000;  default: dcode = 7'b0010000;
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   task automatic push(input int s, input logic d, input logic o,
                       input logic [6:0] d0, input logic [6:0] d1,
                       input logic [6:0] d2, input logic [6:0] d3);
      exp_t e;
      e.step = 7'(s); e.done = d; e.ovf = o;
      e.d0 = d0; e.d1 = d1; e.d2 = d2; e.d3 = d3;
      sb.push_back(e);
   endtask

   // Monitor: a change of step/done/ovf is one DUT output event; seg follows a cycle later.
   logic [8:0] prev_st;
   logic       seg_pend = 1'b0;
   exp_t       pend;

   always @(negedge clk) begin
      if (rst) begin
         prev_st  = 9'd0;
         seg_pend = 1'b0;
      end else begin
         if (seg_pend) begin
            chk("seg", 64'(seg), 64'({BL, pend.d3, pend.d2, pend.d1, pend.d0}));
            seg_pend = 1'b0;
         end
         if ({step, done, ovf} != prev_st) begin
            if (sb.size() == 0) begin
               chk("unexpected_event", 64'({step, done, ovf}), 64'(prev_st));
            end else begin
               pend = sb.pop_front();
               chk("step", 64'(step), 64'(pend.step));
               chk("done", 64'(done), 64'(pend.done));
               chk("ovf",  64'(ovf),  64'(pend.ovf));
               seg_pend = 1'b1;
            end
         end
         prev_st = {step, done, ovf};
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press();
      btn = 1'b1; cyc(12);
      btn = 1'b0; cyc(12);
   endtask

   task automatic beat(input int d, input logic last, input logic exp_rdy);
      mv_valid = 1'b1; mv_data = 2'(d); mv_last = last;
      #1 chk("mv_ready_beat", 64'(mv_ready), 64'(exp_rdy));
      @(negedge clk);
      mv_valid = 1'b0; mv_last = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1; cyc(1); start = 1'b0;
   endtask

   int t6 [12] = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 2, 1, 3};

   initial begin
      // T1: reset values, then reset again mid-LOAD
      cyc(3);
      chk("rst_step", 64'(step), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_ovf",  64'(ovf),  64'd0);
      chk("rst_rdy",  64'(mv_ready), 64'd0);
      chk("rst_seg",  64'(seg), 64'({DIG{BL}}));
      rst = 1'b0;
      #1 chk("rdy_after_release", 64'(mv_ready), 64'd0);
      @(negedge clk);
      chk("rdy_rises", 64'(mv_ready), 64'd1);
      beat(0, 1'b0, 1'b1);
      beat(1, 1'b0, 1'b1);
      beat(2, 1'b0, 1'b1);
      cyc(1);
      rst = 1'b1;
      #1;
      chk("midrst_rdy", 64'(mv_ready), 64'd0);
      chk("midrst_seg", 64'(seg), 64'({DIG{BL}}));
      chk("midrst_step", 64'(step), 64'd0);
      cyc(2);
      rst = 1'b0;
      cyc(1);
      chk("rdy_after_midrst", 64'(mv_ready), 64'd1);

      // T2: load 1,2,3(last) and play three presses
      beat(1, 1'b0, 1'b1);
      beat(2, 1'b0, 1'b1);
      beat(3, 1'b1, 1'b1);
      chk("rdy_wait", 64'(mv_ready), 64'd0);
      push(1, 1'b0, 1'b0, DN, dcode(1), dcode(0), BL); press();
      push(2, 1'b0, 1'b0, LF, dcode(2), dcode(0), BL); press();
      push(3, 1'b1, 1'b0, RT, dcode(3), dcode(0), EE); press();

      // T5a: press in DONE replays from step 0
      push(0, 1'b0, 1'b0, BL, dcode(0), dcode(0), BL); press();

      // T3: bouncing button yields a single step
      push(1, 1'b0, 1'b0, DN, dcode(1), dcode(0), BL);
      repeat (5) begin
         btn = 1'b1; cyc(2);
         btn = 1'b0; cyc(2);
      end
      btn = 1'b1; cyc(10);
      btn = 1'b0; cyc(12);
      chk("bounce_step", 64'(step), 64'd1);

      // T4: overflow with MAXM beats and no last
      push(0, 1'b0, 1'b0, BL, dcode(0), dcode(0), DASH);
      pulse_start();
      push(0, 1'b0, 1'b1, BL, dcode(0), dcode(0), FF);
      for (int i = 0; i < MAXM; i++) beat(i % 4, 1'b0, 1'b1);
      beat(0, 1'b0, 1'b0);
      cyc(2);
      chk("ovf_rdy_low", 64'(mv_ready), 64'd0);

      // T5b: start and press in the same cycle -> start wins
      push(0, 1'b0, 1'b0, BL, dcode(0), dcode(0), DASH);
      btn = 1'b1;
      repeat (DEB + 2) @(posedge clk);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc(1);
      chk("start_wins_rdy", 64'(mv_ready), 64'd1);
      chk("start_wins_step", 64'(step), 64'd0);
      cyc(4);
      btn = 1'b0; cyc(12);

      // T6: tens carry after ten presses
      for (int i = 0; i < MAXM; i++) beat(t6[i], (i == MAXM - 1), 1'b1);
      for (int k = 1; k <= 10; k++) begin
         push(k, 1'b0, 1'b0, mcode(t6[k-1]), dcode(k % 10), dcode(k / 10), BL);
         press();
      end
      chk("carry_tens", 64'(seg[20:14]), 64'(7'b1111001));
      chk("carry_ones", 64'(seg[13:7]),  64'(7'b1000000));

      cyc(20);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
